// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record used by the
// writeback controller and its scoreboard.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       value;
    } wb_req_t;

endpackage

// File: rtl/regfile_writeback_controller_if.sv
// Writeback handshake (ALU and LSU requesters) plus the register-file write port.
// The master modport is the requester/regfile side, slave is the controller.
interface regfile_writeback_controller_if #(
    parameter int XLEN = 32
);
    import regfile_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]       alu_value;
    logic                  alu_ready;

    logic                  lsu_valid;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0]       lsu_value;
    logic                  lsu_ready;

    logic                  write_enable;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       rd_value;

    modport master (
        output alu_valid, alu_rd, alu_value,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_value,
        input  lsu_ready,
        input  write_enable, rd, rd_value
    );

    modport slave (
        input  alu_valid, alu_rd, alu_value,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_value,
        output lsu_ready,
        output write_enable, rd, rd_value
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy bitmap of destination registers with writes in flight; an issue-side set
// beats a writeback-side clear of the same register in the same cycle.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard_rs1,
    output logic                  hazard_rs2,
    output logic [NUM_REGS-1:0]   busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en && (set_rd != REG_ZERO)) begin
            set_vec[set_rd] = 1'b1;
        end
        if (clr_en && (clr_rd != REG_ZERO)) begin
            clr_vec[clr_rd] = 1'b1;
        end
        // Clear first, then set, so the newer in-flight instruction keeps the bit.
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy       = busy_q;
    assign hazard_rs1 = (rs1 != REG_ZERO) && busy_q[rs1];
    assign hazard_rs2 = (rs2 != REG_ZERO) && busy_q[rs2];

endmodule

// File: rtl/regfile_writeback_controller.sv
// Arbitrates ALU/LSU writebacks onto the single register-file write port, with an
// anti-starvation counter for the ALU and a busy scoreboard for hazard detection.
module regfile_writeback_controller
    import regfile_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_writeback_controller_if.slave wb,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    output logic                  hazard_rs1,
    output logic                  hazard_rs2,
    output logic [NUM_REGS-1:0]   busy
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic                  write_enable_q, write_enable_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       rd_value_q, rd_value_d;

    logic                  alu_ready;
    logic                  lsu_ready;
    logic                  grant;
    logic [REG_ADDR_W-1:0] grant_rd;
    logic [XLEN-1:0]       grant_value;
    logic                  grant_writes;

    always_comb begin
        // LSU wins by default; a starved ALU overrides it.
        alu_ready = wb.alu_valid && (!wb.lsu_valid || (starve_cnt_q == STARVE_MAX));
        lsu_ready = wb.lsu_valid && !alu_ready;

        grant       = alu_ready || lsu_ready;
        grant_rd    = alu_ready ? wb.alu_rd    : wb.lsu_rd;
        grant_value = alu_ready ? wb.alu_value : wb.lsu_value;
        grant_writes = grant && (grant_rd != REG_ZERO);

        starve_cnt_d = starve_cnt_q;
        if (!wb.alu_valid || alu_ready) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end

        // x0 writes are consumed but never reach the register file.
        write_enable_d = grant_writes;
        rd_d           = rd_q;
        rd_value_d     = rd_value_q;
        if (grant_writes) begin
            rd_d       = grant_rd;
            rd_value_d = grant_value;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve_cnt_q   <= 4'd0;
            write_enable_q <= 1'b0;
            rd_q           <= REG_ZERO;
            rd_value_q     <= '0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            write_enable_q <= write_enable_d;
            rd_q           <= rd_d;
            rd_value_q     <= rd_value_d;
        end
    end

    assign wb.alu_ready    = alu_ready;
    assign wb.lsu_ready    = lsu_ready;
    assign wb.write_enable = write_enable_q;
    assign wb.rd           = rd_q;
    assign wb.rd_value     = rd_value_q;

    regfile_scoreboard u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_en     (issue_valid),
        .set_rd     (issue_rd),
        .clr_en     (grant_writes),
        .clr_rd     (grant_rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard_rs1 (hazard_rs1),
        .hazard_rs2 (hazard_rs2),
        .busy       (busy)
    );

endmodule

// File: doc/regfile_writeback_controller.md
# regfile_writeback_controller

Sequences all writes into the 32×32 register file. It arbitrates between two writeback requesters, the ALU and the load/store unit (LSU), and drives the register file's single write port. It also keeps a busy scoreboard of destination registers with writes in flight, so the issue stage can detect read-after-write hazards on rs1/rs2. It sits between the execute/memory stages and `register_file`.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive cycles the ALU may be denied before it is forced to win (range 1..15).

Ports:
- `clock`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low.
- `alu_valid`  in  1  ALU writeback request.
- `alu_rd`  in  5  ALU destination register.
- `alu_value`  in  XLEN  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `lsu_valid`  in  1  LSU writeback request.
- `lsu_rd`  in  5  LSU destination register.
- `lsu_value`  in  XLEN  Load data.
- `lsu_ready`  out  1  LSU request accepted this cycle.
- `write_enable`  out  1  Register file write strobe (registered).
- `rd`  out  5  Register file write address (registered).
- `rd_value`  out  XLEN  Register file write data (registered).
- `issue_valid`  in  1  An instruction with a destination register issues this cycle.
- `issue_rd`  in  5  Its destination register.
- `rs1`  in  5  Issue-stage source register 1.
- `rs2`  in  5  Issue-stage source register 2.
- `hazard_rs1`  out  1  `rs1` is busy (combinational).
- `hazard_rs2`  out  1  `rs2` is busy (combinational).
- `busy`  out  32  Scoreboard bitmap; bit 0 is always 0.

## Operation
- At most one grant per cycle; a request is accepted when `*_valid && *_ready`.
- `*_ready` is combinational from the valids and the starvation counter; it never depends on `issue_*`.
- Priority: LSU wins by default.
  - Exception: when `starve_cnt == STARVE_LIMIT` and `alu_valid` is high, the ALU wins and the LSU is stalled.
  - A lone requester is always granted.
- `starve_cnt` (4 bits) behaviour, per cycle:
  - Increments while `alu_valid && !alu_ready`.
  - Clears to 0 on an ALU grant or when `alu_valid` is low.
  - Saturates at `STARVE_LIMIT`.
- Accepted request with `rd != 0`: next cycle `write_enable=1`, with `rd`/`rd_value` taken from the granted requester.
- Accepted request with `rd == 0`: the request is consumed (ready high), but next cycle `write_enable=0`. The register file never sees an x0 write.
- No grant: next cycle `write_enable=0`; `rd`/`rd_value` hold their previous values.
- Scoreboard update, per cycle:
  - Set `busy[issue_rd]` on `issue_valid && issue_rd != 0`.
  - Clear `busy[rd]` on the accept of a request whose `rd != 0`. The clear happens at the accept edge, the same edge that registers the write.
- Same register set and cleared in the same cycle: the set wins (the newer instruction is in flight).
- Hazard outputs: `hazard_rsN = busy[rsN]`; `rsN == 0` never produces a hazard.
- Requesters must keep `valid`/`rd`/`value` stable until accepted; the block does not check this.

## Timing
- Reset (async assert, sync deassert handled upstream):
  - `write_enable=0`, `rd=0`, `rd_value=0`.
  - `busy=0`, `starve_cnt=0`.
  - `alu_ready`/`lsu_ready` follow the valids combinationally, but no state changes occur while `reset` is low.
- Accept-to-write latency is 1 cycle: the write strobe is high in the cycle after the handshake, and the register file captures it at the following edge.
- Throughput: one write per cycle sustained.
- Scoreboard clear precedes the register file update by one cycle. The issue stage must bypass from the `rd`/`rd_value` outputs when `write_enable` is high and `rd` matches a source.
- Reset asserted mid-stream: the in-flight output write is dropped (`write_enable` forced to 0 immediately) and all busy bits are lost. The pipeline is flushed by the same reset.

## Structure
- Shared package `regfile_pkg`:
  - `REG_ADDR_W = 5`, `NUM_REGS = 32`, `XLEN`.
  - Typedef `wb_req_t` {valid, rd, value}.
  - Constant `REG_ZERO = 5'd0`.
- One natural sub-module: `regfile_scoreboard`, holding the busy bitmap, set/clear priority and hazard lookup.
- Arbitration, the starvation counter and the output register stay in the top level.

## Test plan
- Single ALU request (`rd=5`, value `0xDEADBEEF`, LSU idle) -> `alu_ready=1` the same cycle; next cycle `write_enable=1`, `rd=5`, `rd_value=0xDEADBEEF`.
- Both valid (ALU `rd=3`, LSU `rd=4`) -> LSU granted, ALU stalled. With LSU held valid continuously, ALU is granted on the 5th cycle (`STARVE_LIMIT=4`), then `starve_cnt` returns to 0.
- LSU request with `rd=0`, value `0x12345678` -> `lsu_ready=1`; next cycle `write_enable=0`; `busy` unchanged.
- `issue_valid` with `issue_rd=7` -> `busy[7]=1` next cycle and `hazard_rs1=1` when `rs1=7`. After an ALU accept with `rd=7`, `busy[7]=0`.
- Same cycle `issue_rd=9` and LSU accept with `rd=9` (while `busy[9]=1`) -> `busy[9]` remains 1.
- Reset pulled low one cycle after an accept -> `write_enable` drops to 0 immediately; `busy=0` and `starve_cnt=0` after release.
